sram_access_arbiter: RTL and testbench
======================================

# sram_access_arbiter

Single-port access controller for the result SRAM (2048 × 32-bit words). Shares the SRAM between two requesters: the convolution write-back path, which delivers packed pairs of 16-bit kernel results, and a host port, which reads and writes result words. It schedules one access per cycle, bounds host starvation during long convolution bursts and returns host read data through a registered pipeline. It sits between the result register / control FSM and the SRAM wrapper.

## Interface
- CONV_MAX_RUN, 8: maximum number of consecutive conv grants while host_req is pending (1..255).
- CLK  in  1  clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- conv_req  in  1  conv write request; held with conv_addr and conv_wdata until granted.
- conv_addr  in  11  conv write word address.
- conv_wdata  in  32  conv write data, {res_b, res_a}.
- conv_gnt  out  1  conv access performed this cycle.
- host_req  in  1  host request; held with its fields until granted.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  11  host word address.
- host_wdata  in  32  host write data.
- host_gnt  out  1  host access performed this cycle.
- host_rvalid  out  1  host_rdata valid for one cycle.
- host_rdata  out  32  host read data.
- sram_ready  in  1  SRAM accepts an access this cycle.
- sram_writen  out  1  SRAM write strobe, active low.
- sram_addr  out  11  SRAM address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid the cycle after the read access.
- conv_grant_cnt  out  16  perf counter (see Configuration).
- host_stall_cnt  out  16  perf counter (see Configuration).

## Operation
- Grant is combinational from the current requests and the registered state. At most one of conv_gnt and host_gnt is high. Both are 0 when sram_ready = 0.
- States: CONV_PRI and HOST_PRI.
  - In CONV_PRI: conv wins if conv_req = 1, else host wins.
  - In HOST_PRI: host wins if host_req = 1, else conv wins.
- run_cnt (8 bits):
  - Increments on each conv_gnt while host_req = 1.
  - Clears on any host_gnt, and on any cycle with host_req = 0.
- State transitions:
  - CONV_PRI → HOST_PRI when a conv_gnt makes run_cnt reach CONV_MAX_RUN.
  - HOST_PRI → CONV_PRI on host_gnt.
- Granted access drives the sram_* outputs from the winner in the same cycle.
- sram_writen = 0 only for a conv grant or a host write grant. It is 1 for a host read and in idle cycles.
- Idle cycles: sram_addr and sram_wdata hold their last values, so the SRAM inputs do not toggle.
- Host read: on the next cycle, sram_rdata is captured into host_rdata. host_rvalid is high for the cycle after that capture.
- Writes do not generate host_rvalid.
- The read pipeline is independent of arbitration, so back-to-back host reads give back-to-back rvalid pulses.

## Timing
- Reset values:
  - conv_gnt = 0, host_gnt = 0, host_rvalid = 0, host_rdata = 0.
  - sram_writen = 1, sram_addr = 0, sram_wdata = 0.
  - State = CONV_PRI, run_cnt = 0, both counters = 0.
- Grant latency: 0 cycles from a valid request when the SRAM is ready and the requester wins.
- Host read latency: host_rvalid rises 2 cycles after host_gnt.
- Reset asserted mid-read: the pending read is discarded and no rvalid is issued.
- sram_ready = 0: no grant. run_cnt and the state hold.
- Simultaneous requests after reset: conv wins.
- Conv and host writing the same address in consecutive cycles: the later grant wins, with no merging.
- Host read of an address written by conv in the previous cycle returns the new data. The SRAM is write-first across cycles.

## Configuration
- ARB_PERF_CNT_EN defined:
  - conv_grant_cnt increments on each conv_gnt.
  - host_stall_cnt increments on each cycle with host_req = 1 and host_gnt = 0.
  - Both are 16-bit, saturate at 0xFFFF and clear on RESET.
- ARB_PERF_CNT_EN undefined: both outputs are tied to 0 and no counter flops are present.

## Structure
- Shared package (sram_arb_pkg):
  - SRAM_AW = 11, SRAM_DW = 32.
  - typedef enum of arb_state_t {CONV_PRI, HOST_PRI}.
  - typedef of the request struct {addr, wdata, we}.
- One sub-module, sram_arb_rd_pipe: the two-stage host read capture and rvalid generation.

## Test plan
- Isolated host read: conv_req = 0, host read at addr 0x005 after conv wrote 0xDEADBEEF there → host_gnt in the same cycle, host_rvalid 2 cycles later, host_rdata = 0xDEADBEEF.
- Contention: conv_req held high for 20 cycles and host_req (write) high from cycle 0, CONV_MAX_RUN = 8 → 8 conv_gnt, then host_gnt on cycle 8, then conv resumes.
- Stall: sram_ready low for 3 cycles with both requests high → no grants, sram_writen = 1, run_cnt unchanged, grants resume when sram_ready returns high.
- Back-to-back host reads at addr 0x010, 0x011, 0x012 → three consecutive rvalid pulses with data in order.
- RESET asserted 1 cycle after a host read grant → no host_rvalid, all outputs at reset values on the next cycle.
- With ARB_PERF_CNT_EN: the contention case gives conv_grant_cnt = 19 and host_stall_cnt = 8. Without it, both counters read 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the result-SRAM access arbiter.
// Perf counters are built only when ARB_PERF_CNT_EN is defined.
package sram_arb_pkg;

    localparam int SRAM_AW = 11;
    localparam int SRAM_DW = 32;
    localparam int RUN_W   = 8;
    localparam int CNT_W   = 16;

    typedef enum logic {
        CONV_PRI = 1'b0,
        HOST_PRI = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [SRAM_AW-1:0] addr;
        logic [SRAM_DW-1:0] wdata;
        logic               we;
    } sram_req_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sram_arb_rd_pipe.sv
// Host read return path: captures SRAM data the cycle after a read
// access and flags it valid for one cycle.
module sram_arb_rd_pipe
    import sram_arb_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               rd_issue_i,
    input  logic [SRAM_DW-1:0] sram_rdata_i,
    output logic               host_rvalid_o,
    output logic [SRAM_DW-1:0] host_rdata_o
);

    logic               rd_pend_q;
    logic               rvalid_q;
    logic [SRAM_DW-1:0] rdata_q;
    logic [SRAM_DW-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (rd_pend_q) begin
            rdata_d = sram_rdata_i;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_pend_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rd_pend_q <= rd_issue_i;
            rvalid_q  <= rd_pend_q;
            rdata_q   <= rdata_d;
        end
    end

    assign host_rvalid_o = rvalid_q;
    assign host_rdata_o  = rdata_q;

endmodule

// File: rtl/sram_access_arbiter.sv
// Single-port result-SRAM arbiter: conv write-back vs host port.
// Define ARB_PERF_CNT_EN to build the grant/stall perf counters.
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int CONV_MAX_RUN = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               conv_req,
    input  logic [SRAM_AW-1:0] conv_addr,
    input  logic [SRAM_DW-1:0] conv_wdata,
    output logic               conv_gnt,
    input  logic               host_req,
    input  logic               host_we,
    input  logic [SRAM_AW-1:0] host_addr,
    input  logic [SRAM_DW-1:0] host_wdata,
    output logic               host_gnt,
    output logic               host_rvalid,
    output logic [SRAM_DW-1:0] host_rdata,
    input  logic               sram_ready,
    output logic               sram_writen,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_wdata,
    input  logic [SRAM_DW-1:0] sram_rdata,
    output logic [CNT_W-1:0]   conv_grant_cnt,
    output logic [CNT_W-1:0]   host_stall_cnt
);

    localparam logic [RUN_W-1:0] MAX_RUN = RUN_W'(CONV_MAX_RUN);

    arb_state_t       state_q, state_d;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    sram_req_t        conv_r, host_r, win_r;
    sram_req_t        last_q, last_d;
    logic             conv_win, host_win, any_win;

    always_comb begin
        conv_r = '{addr: conv_addr, wdata: conv_wdata, we: 1'b1};
        host_r = '{addr: host_addr, wdata: host_wdata, we: host_we};
    end

    always_comb begin
        conv_win = 1'b0;
        host_win = 1'b0;
        if (sram_ready && !RESET) begin
            unique case (state_q)
                CONV_PRI: begin
                    conv_win = conv_req;
                    host_win = host_req & ~conv_req;
                end
                HOST_PRI: begin
                    host_win = host_req;
                    conv_win = conv_req & ~host_req;
                end
            endcase
        end
    end

    // A stalled SRAM freezes both the run counter and the priority state.
    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        if (sram_ready) begin
            if (host_win || !host_req) begin
                run_cnt_d = '0;
            end else if (conv_win) begin
                run_cnt_d = run_cnt_q + 1'b1;
            end
            if (host_win) begin
                state_d = CONV_PRI;
            end else if (state_q == CONV_PRI && conv_win &&
                         host_req && run_cnt_d == MAX_RUN) begin
                state_d = HOST_PRI;
            end
        end
    end

    always_comb begin
        any_win = conv_win | host_win;
        win_r   = conv_win ? conv_r : host_r;
        last_d  = any_win ? win_r : last_q;
    end

    assign conv_gnt    = conv_win;
    assign host_gnt    = host_win;
    assign sram_writen = ~(any_win & win_r.we);
    assign sram_addr   = last_d.addr;
    assign sram_wdata  = last_d.wdata;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= CONV_PRI;
            run_cnt_q <= '0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            last_q    <= last_d;
        end
    end

    sram_arb_rd_pipe u_rd_pipe (
        .CLK           (CLK),
        .RESET         (RESET),
        .rd_issue_i    (host_win & ~host_we),
        .sram_rdata_i  (sram_rdata),
        .host_rvalid_o (host_rvalid),
        .host_rdata_o  (host_rdata)
    );

`ifdef ARB_PERF_CNT_EN
    logic [CNT_W-1:0] cg_cnt_q, cg_cnt_d;
    logic [CNT_W-1:0] hs_cnt_q, hs_cnt_d;

    always_comb begin
        cg_cnt_d = cg_cnt_q;
        hs_cnt_d = hs_cnt_q;
        if (conv_win) begin
            cg_cnt_d = sat_inc(cg_cnt_q);
        end
        if (host_req && !host_win) begin
            hs_cnt_d = sat_inc(hs_cnt_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cg_cnt_q <= '0;
            hs_cnt_q <= '0;
        end else begin
            cg_cnt_q <= cg_cnt_d;
            hs_cnt_q <= hs_cnt_d;
        end
    end

    assign conv_grant_cnt = cg_cnt_q;
    assign host_stall_cnt = hs_cnt_q;
`else
    assign conv_grant_cnt = '0;
    assign host_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Scoreboard bench for sram_access_arbiter with an SRAM model and a
// cycle-level reference of the arbitration rules.
module tb_sram_access_arbiter;

    localparam int MAX_RUN = 8;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        conv_req = 1'b0;
    logic [10:0] conv_addr = '0;
    logic [31:0] conv_wdata = '0;
    logic        conv_gnt;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [10:0] host_addr = '0;
    logic [31:0] host_wdata = '0;
    logic        host_gnt;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic        sram_ready = 1'b1;
    logic        sram_writen;
    logic [10:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = '0;
    logic [15:0] conv_grant_cnt;
    logic [15:0] host_stall_cnt;

    sram_access_arbiter #(.CONV_MAX_RUN(MAX_RUN)) dut (
        .CLK(CLK), .RESET(RESET),
        .conv_req(conv_req), .conv_addr(conv_addr),
        .conv_wdata(conv_wdata), .conv_gnt(conv_gnt),
        .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata), .sram_ready(sram_ready),
        .sram_writen(sram_writen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .conv_grant_cnt(conv_grant_cnt),
        .host_stall_cnt(host_stall_cnt)
    );

    always #5 CLK = ~CLK;

    // SRAM model, write-first: a write is visible to any later read.
    logic [31:0] smem [2048];
    always @(posedge CLK) begin
        if (sram_ready) begin
            if (!sram_writen) begin
                smem[sram_addr] <= sram_wdata;
                sram_rdata      <= sram_wdata;
            end else begin
                sram_rdata <= smem[sram_addr];
            end
        end
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        tests++;
        fails++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    typedef struct {
        logic [31:0] data;
        bit          known;
        int          due;
    } rd_exp_t;

    rd_exp_t     rq[$];
    logic [31:0] refmem[int];
    bit          m_hprio = 0;
    int          m_run = 0;
    logic [10:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] exp_rdata = '0;
    int          m_cg = 0;
    int          m_hs = 0;
    bit          c_seen = 0;
    bit          h_seen = 0;

    // Monitor + reference model, evaluated mid-cycle on stable inputs.
    initial begin
        forever begin
            bit          eg_c, eg_h;
            logic [10:0] ea;
            logic [31:0] ew;
            rd_exp_t     e;
            @(negedge CLK);
            cyc++;
            if (host_rvalid) begin
                if (rq.size() == 0) begin
                    flag("rvalid_unexpected");
                end else begin
                    e = rq.pop_front();
                    chk("rvalid_time", cyc, e.due);
                    if (e.known) begin
                        chk("rdata", host_rdata, e.data);
                        exp_rdata = e.data;
                    end else begin
                        exp_rdata = host_rdata;
                    end
                end
            end else if (rq.size() != 0 && rq[0].due <= cyc) begin
                e = rq.pop_front();
                flag("rvalid_missing");
            end
            chk("rdata_hold", host_rdata, exp_rdata);

            eg_c = 0;
            eg_h = 0;
            if (!RESET && sram_ready) begin
                if (m_hprio) begin
                    eg_h = host_req;
                    eg_c = conv_req && !host_req;
                end else begin
                    eg_c = conv_req;
                    eg_h = host_req && !conv_req;
                end
            end
            ea = eg_c ? conv_addr : (eg_h ? host_addr : m_addr);
            ew = eg_c ? conv_wdata : (eg_h ? host_wdata : m_wdata);
            chk("conv_gnt", conv_gnt, eg_c);
            chk("host_gnt", host_gnt, eg_h);
            chk("sram_writen", sram_writen, !(eg_c || (eg_h && host_we)));
            chk("sram_addr", sram_addr, ea);
            chk("sram_wdata", sram_wdata, ew);
`ifdef ARB_PERF_CNT_EN
            chk("conv_grant_cnt", conv_grant_cnt, m_cg);
            chk("host_stall_cnt", host_stall_cnt, m_hs);
`else
            chk("conv_grant_cnt", conv_grant_cnt, 0);
            chk("host_stall_cnt", host_stall_cnt, 0);
`endif
            c_seen = conv_gnt;
            h_seen = host_gnt;

            if (RESET) begin
                m_hprio = 0;
                m_run = 0;
                m_addr = '0;
                m_wdata = '0;
                m_cg = 0;
                m_hs = 0;
                exp_rdata = '0;
                rq.delete();
            end else begin
                if (eg_c) begin
                    refmem[int'(conv_addr)] = conv_wdata;
                end
                if (eg_h && host_we) begin
                    refmem[int'(host_addr)] = host_wdata;
                end
                if (eg_h && !host_we) begin
                    e.known = refmem.exists(int'(host_addr));
                    e.data = e.known ? refmem[int'(host_addr)] : '0;
                    e.due = cyc + 2;
                    rq.push_back(e);
                end
                m_addr = ea;
                m_wdata = ew;
                if (sram_ready) begin
                    if (eg_h) begin
                        m_run = 0;
                        m_hprio = 0;
                    end else if (!host_req) begin
                        m_run = 0;
                    end else if (eg_c) begin
                        m_run++;
                        if (!m_hprio && m_run == MAX_RUN) m_hprio = 1;
                    end
                end
                if (eg_c && m_cg < 65535) m_cg++;
                if (host_req && !eg_h && m_hs < 65535) m_hs++;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic host_op(input logic we, input logic [10:0] a,
                           input logic [31:0] d);
        int n;
        host_req = 1'b1;
        host_we = we;
        host_addr = a;
        host_wdata = d;
        n = 0;
        do begin
            step();
            n++;
        end while (!h_seen && n < 100);
        if (!h_seen) flag("host_grant_timeout");
        host_req = 1'b0;
    endtask

    task automatic conv_op(input logic [10:0] a, input logic [31:0] d);
        int n;
        conv_req = 1'b1;
        conv_addr = a;
        conv_wdata = d;
        n = 0;
        do begin
            step();
            n++;
        end while (!c_seen && n < 100);
        if (!c_seen) flag("conv_grant_timeout");
        conv_req = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_rvalid"}, host_rvalid, 0);
        chk({nm, "_rdata"}, host_rdata, 0);
        chk({nm, "_writen"}, sram_writen, 1);
        chk({nm, "_addr"}, sram_addr, 0);
        chk({nm, "_wdata"}, sram_wdata, 0);
    endtask

    initial begin
        int h_idx, nconv, n;
        idle(3);
        RESET = 1'b0;
        chk_reset_outs("reset");

        // Isolated host read of a word conv just wrote.
        conv_op(11'h005, 32'hDEADBEEF);
        host_op(1'b0, 11'h005, '0);
        idle(4);

        // Contention: conv held 20 cycles, host write pending from cycle 0.
        do_reset();
        conv_req = 1'b1;
        conv_addr = 11'($urandom_range(0, 31));
        conv_wdata = $urandom;
        host_req = 1'b1;
        host_we = 1'b1;
        host_addr = 11'h020;
        host_wdata = 32'h0BADF00D;
        h_idx = -1;
        nconv = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (h_seen && h_idx < 0) begin
                h_idx = i;
                host_req = 1'b0;
            end
            if (c_seen) begin
                nconv++;
                conv_addr = 11'($urandom_range(0, 31));
                conv_wdata = $urandom;
            end
            if (i == 19) conv_req = 1'b0;
        end
        idle(2);
        chk("contention_host_slot", h_idx, 8);
        chk("contention_conv_grants", nconv, 19);
`ifdef ARB_PERF_CNT_EN
        chk("perf_conv_grant", conv_grant_cnt, 19);
        chk("perf_host_stall", host_stall_cnt, 8);
`else
        chk("perf_conv_grant_off", conv_grant_cnt, 0);
        chk("perf_host_stall_off", host_stall_cnt, 0);
`endif

        // SRAM stall with both requesters waiting.
        sram_ready = 1'b0;
        conv_req = 1'b1;
        conv_addr = 11'h007;
        conv_wdata = 32'h11112222;
        host_req = 1'b1;
        host_we = 1'b0;
        host_addr = 11'h005;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_no_grant", {c_seen, h_seen}, 2'b00);
        end
        sram_ready = 1'b1;
        n = 0;
        while ((conv_req || host_req) && n < 50) begin
            step();
            n++;
            if (c_seen) conv_req = 1'b0;
            if (h_seen) host_req = 1'b0;
        end
        if (conv_req || host_req) flag("stall_resume_timeout");
        conv_req = 1'b0;
        host_req = 1'b0;
        idle(3);

        // Back-to-back host reads.
        host_op(1'b1, 11'h010, 32'hA0A0A0A0);
        host_op(1'b1, 11'h011, 32'hB1B1B1B1);
        host_op(1'b1, 11'h012, 32'hC2C2C2C2);
        host_op(1'b0, 11'h010, '0);
        host_op(1'b0, 11'h011, '0);
        host_op(1'b0, 11'h012, '0);
        idle(4);

        // Reset one cycle after a read grant discards the read.
        host_op(1'b0, 11'h011, '0);
        do_reset();
        chk_reset_outs("midread_reset");
        idle(4);

        // Randomised traffic with SRAM back-pressure and rare resets.
        for (int i = 0; i < 4000; i++) begin
            if (!conv_req || c_seen) begin
                conv_req = ($urandom_range(0, 99) < 60);
                conv_addr = 11'($urandom_range(0, 31));
                conv_wdata = $urandom;
            end
            if (!host_req || h_seen) begin
                host_req = ($urandom_range(0, 99) < 50);
                host_we = $urandom_range(0, 1) == 1;
                host_addr = 11'($urandom_range(0, 31));
                host_wdata = $urandom;
            end
            sram_ready = ($urandom_range(0, 4) != 0);
            RESET = ($urandom_range(0, 199) == 0);
            step();
        end
        RESET = 1'b0;
        conv_req = 1'b0;
        host_req = 1'b0;
        sram_ready = 1'b1;
        idle(5);
        chk("final_queue_empty", rq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
